id_ex_operand_stage: RTL

- Decode-to-execute pipeline stage placed directly downstream of the register bank.
- Drives the bank's two read addresses and captures the two read operands into an ID/EX register.
- Resolves data hazards by forwarding from EX and WB, and stalls on load-use.
- Exchanges valid/ready handshakes with decode (upstream) and execute (downstream).

---
 rtl/id_ex_operand_stage_if.sv | 37 +++
 rtl/id_ex_operand_stage.sv | 122 ++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side and execute-side handshake bundle of the ID/EX operand stage.
// The stage connects through the slave modport; decode/EX drive the master side.
interface id_ex_operand_stage_if #(
    parameter int BIT_ADDR = 5,
    parameter int BIT_DATO = 32,
    parameter int CTRL_W   = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [BIT_ADDR-1:0] in_rs1;
    logic [BIT_ADDR-1:0] in_rs2;
    logic [BIT_ADDR-1:0] in_rd;
    logic                in_use_rs1;
    logic                in_use_rs2;
    logic [CTRL_W-1:0]   in_ctrl;

    logic                out_valid;
    logic                out_ready;
    logic [BIT_DATO-1:0] op_a;
    logic [BIT_DATO-1:0] op_b;
    logic [BIT_ADDR-1:0] rd_out;
    logic [CTRL_W-1:0]   ctrl_out;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_ctrl,
        input  in_ready,
        input  out_valid, op_a, op_b, rd_out, ctrl_out,
        output out_ready
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_ctrl,
        output in_ready,
        output out_valid, op_a, op_b, rd_out, ctrl_out,
        input  out_ready
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: reads the register bank, forwards from EX/WB, stalls on
// load-use and holds a single registered entry toward execute.
module id_ex_operand_stage #(
    parameter int BIT_ADDR = 5,
    parameter int BIT_DATO = 32,
    parameter int CTRL_W   = 8,
    parameter int R0_ZERO  = 1
) (
    input  logic                clk,
    input  logic                rst,
    id_ex_operand_stage_if.slave bus,
    output logic [BIT_ADDR-1:0] addrRa,
    output logic [BIT_ADDR-1:0] addrRb,
    input  logic [BIT_DATO-1:0] datOutRa,
    input  logic [BIT_DATO-1:0] datOutRb,
    input  logic                ex_valid,
    input  logic                ex_regwrite,
    input  logic                ex_memread,
    input  logic [BIT_ADDR-1:0] ex_rd,
    input  logic [BIT_DATO-1:0] ex_data,
    input  logic                wb_we,
    input  logic [BIT_ADDR-1:0] wb_rd,
    input  logic [BIT_DATO-1:0] wb_data,
    input  logic                flush,
    output logic [15:0]         stall_cnt
);
    localparam bit R0Z = (R0_ZERO != 0);

    logic [BIT_ADDR-1:0] srcAddr [2];
    logic [BIT_DATO-1:0] bankDat [2];
    logic [1:0]          srcUse;
    logic [1:0]          srcNonZero;
    logic [1:0]          hitEx;
    logic [1:0]          hitWb;
    logic [1:0]          snoopHit;
    logic [BIT_DATO-1:0] opNext [2];

    logic                outValidReg;
    logic [BIT_DATO-1:0] opReg [2];
    logic [BIT_ADDR-1:0] heldAddrReg [2];
    logic [1:0]          heldUseReg;
    logic [BIT_ADDR-1:0] rdReg;
    logic [CTRL_W-1:0]   ctrlReg;
    logic [15:0]         stallCntReg;

    logic exWe;
    logic loadUse;
    logic inReady;
    logic capture;

    assign srcAddr[0] = bus.in_rs1;
    assign srcAddr[1] = bus.in_rs2;
    assign srcUse     = {bus.in_use_rs2, bus.in_use_rs1};
    assign bankDat[0] = datOutRa;
    assign bankDat[1] = datOutRb;
    assign exWe       = ex_valid & ex_regwrite;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gSrc
            assign srcNonZero[gi] = !R0Z || (srcAddr[gi] != '0);
            assign hitEx[gi] = srcUse[gi] && srcNonZero[gi] && exWe && (ex_rd == srcAddr[gi]);
            assign hitWb[gi] = srcUse[gi] && srcNonZero[gi] && wb_we && (wb_rd == srcAddr[gi]);
            // The bank writes on the same edge we capture, so its read is stale on a WB hit.
            assign opNext[gi] = !srcNonZero[gi] ? '0      :
                                hitEx[gi]       ? ex_data :
                                hitWb[gi]       ? wb_data :
                                                  bankDat[gi];
            assign snoopHit[gi] = heldUseReg[gi] && wb_we && (wb_rd == heldAddrReg[gi]) &&
                                  (!R0Z || (heldAddrReg[gi] != '0));
        end
    endgenerate

    assign loadUse = bus.in_valid && ex_valid && ex_memread && (hitEx != 2'b00);
    assign inReady = (!outValidReg || bus.out_ready) && !loadUse && !flush;
    assign capture = bus.in_valid && inReady;

    always_ff @(posedge clk) begin
        if (!rst) begin
            outValidReg <= 1'b0;
            heldUseReg  <= '0;
            rdReg       <= '0;
            ctrlReg     <= '0;
            stallCntReg <= '0;
            for (int i = 0; i < 2; i++) begin
                opReg[i]       <= '0;
                heldAddrReg[i] <= '0;
            end
        end else begin
            if (loadUse && (stallCntReg != 16'hFFFF))
                stallCntReg <= stallCntReg + 16'd1;

            if (flush) begin
                outValidReg <= 1'b0;
            end else if (capture) begin
                outValidReg <= 1'b1;
                rdReg       <= bus.in_rd;
                ctrlReg     <= bus.in_ctrl;
                heldUseReg  <= srcUse;
                for (int i = 0; i < 2; i++) begin
                    opReg[i]       <= opNext[i];
                    heldAddrReg[i] <= srcAddr[i];
                end
            end else if (outValidReg && bus.out_ready) begin
                outValidReg <= 1'b0;
            end else if (outValidReg) begin
                // EX is stalled behind us, so only WB can still produce a newer value.
                for (int i = 0; i < 2; i++)
                    if (snoopHit[i]) opReg[i] <= wb_data;
            end
        end
    end

    assign addrRa       = bus.in_rs1;
    assign addrRb       = bus.in_rs2;
    assign bus.in_ready = inReady;
    assign bus.out_valid = outValidReg;
    assign bus.op_a     = opReg[0];
    assign bus.op_b     = opReg[1];
    assign bus.rd_out   = rdReg;
    assign bus.ctrl_out = ctrlReg;
    assign stall_cnt    = stallCntReg;
endmodule
